// File: rtl/pp_pipeline_accel_start_token_consumer.sv
// Read side of a dataflow start-token FIFO driving the ap_ctrl_chain handshake of one
// downstream process; bounds launched-but-not-retired tasks and buffers one completion.
module pp_pipeline_accel_start_token_consumer #(
    parameter int DATA_WIDTH   = 1,
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start_empty_n,
    output logic                  start_read,
    input  logic [DATA_WIDTH-1:0] start_dout,
    output logic                  task_ap_start,
    input  logic                  task_ap_ready,
    input  logic                  task_ap_done,
    output logic                  task_ap_continue,
    output logic [DATA_WIDTH-1:0] token_q,
    output logic                  done_valid,
    input  logic                  done_ack,
    output logic [CNT_WIDTH-1:0]  launch_cnt,
    output logic [CNT_WIDTH-1:0]  done_cnt,
    output logic                  busy,
    output logic                  err
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAX_IF = IW'(MAX_INFLIGHT);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LAUNCH = 1'b1;

    logic [0:0]            r_state;
    logic [IW-1:0]         r_inflight;
    logic [DATA_WIDTH-1:0] r_token;
    logic                  r_done_valid;
    logic [CNT_WIDTH-1:0]  r_launch_cnt;
    logic [CNT_WIDTH-1:0]  r_done_cnt;
    logic                  r_err;

    logic w_pop;
    logic w_launch;
    logic w_cont;
    logic w_underflow;
    logic w_dec;
    logic w_ready_err;

    // Strobes are gated by reset so nothing leaks to the FIFO or process while held.
    assign w_pop       = ap_rst_n & (r_state == S_IDLE) & start_empty_n & (r_inflight < MAX_IF);
    assign w_launch    = (r_state == S_LAUNCH) & task_ap_ready;
    assign w_cont      = ap_rst_n & task_ap_done & ~r_done_valid;
    assign w_underflow = w_cont & (r_inflight == '0);
    assign w_dec       = w_cont & ~w_underflow;
    assign w_ready_err = task_ap_ready & (r_state != S_LAUNCH);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state      <= S_IDLE;
            r_inflight   <= '0;
            r_token      <= '0;
            r_done_valid <= 1'b0;
            r_launch_cnt <= '0;
            r_done_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_pop) begin
                    r_state <= S_LAUNCH;
                    r_token <= start_dout;
                end
            end else if (task_ap_ready) begin
                r_state <= S_IDLE;
            end

            if (w_launch)
                r_launch_cnt <= r_launch_cnt + CNT_WIDTH'(1);
            if (w_cont)
                r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);

            // Only one completion is buffered; continue is withheld while it is pending.
            if (w_cont)
                r_done_valid <= 1'b1;
            else if (done_ack)
                r_done_valid <= 1'b0;

            if (w_launch && !w_dec)
                r_inflight <= r_inflight + IW'(1);
            else if (!w_launch && w_dec)
                r_inflight <= r_inflight - IW'(1);

            if (w_underflow || w_ready_err)
                r_err <= 1'b1;
        end
    end

    assign start_read       = w_pop;
    assign task_ap_start    = (r_state == S_LAUNCH);
    assign task_ap_continue = w_cont;
    assign token_q          = r_token;
    assign done_valid       = r_done_valid;
    assign launch_cnt       = r_launch_cnt;
    assign done_cnt         = r_done_cnt;
    assign busy             = (r_state == S_LAUNCH) | (r_inflight != '0) | r_done_valid;
    assign err              = r_err;

endmodule

// File: tb/tb_pp_pipeline_accel_start_token_consumer.sv
// Randomized bench: FIFO, downstream process and controller models drive the DUT;
// a negedge monitor compares against a task-level reference model and token scoreboard.
module tb_pp_pipeline_accel_start_token_consumer;

    localparam int DW = 1;
    localparam int MI = 2;
    localparam int CW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          start_empty_n = 1'b0;
    logic          start_read;
    logic [DW-1:0] start_dout = '0;
    logic          task_ap_start;
    logic          task_ap_ready = 1'b0;
    logic          task_ap_done = 1'b0;
    logic          task_ap_continue;
    logic [DW-1:0] token_q;
    logic          done_valid;
    logic          done_ack = 1'b0;
    logic [CW-1:0] launch_cnt;
    logic [CW-1:0] done_cnt;
    logic          busy;
    logic          err;

    pp_pipeline_accel_start_token_consumer #(
        .DATA_WIDTH(DW), .MAX_INFLIGHT(MI), .CNT_WIDTH(CW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .start_empty_n(start_empty_n), .start_read(start_read), .start_dout(start_dout),
        .task_ap_start(task_ap_start), .task_ap_ready(task_ap_ready),
        .task_ap_done(task_ap_done), .task_ap_continue(task_ap_continue),
        .token_q(token_q), .done_valid(done_valid), .done_ack(done_ack),
        .launch_cnt(launch_cnt), .done_cnt(done_cnt), .busy(busy), .err(err)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus-side state: token FIFO and downstream process completion times.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_tok[$];
    longint        proc_q[$];
    longint        cyc = 0;
    int            push_pct = 0, rdy_pct = 100, ack_pct = 100, lat_lo = 0, lat_hi = 0;
    bit            force_rdy = 0, force_done = 0;
    int            pushed_since_rst = 0;

    // Events observed by the monitor, consumed by the driver after the following edge.
    bit pop_evt = 0, launch_evt = 0, cont_evt = 0;

    // Reference model of the task-level state.
    bit            m_launching = 0;
    int            m_infl = 0;
    logic [CW-1:0] m_launch = '0, m_done = '0;
    bit            m_dv = 0, m_err = 0;
    logic [DW-1:0] m_tok = '0;

    always @(negedge ap_clk) begin
        bit was_launching;
        chk("launch_cnt", 64'(launch_cnt), 64'(m_launch));
        chk("done_cnt", 64'(done_cnt), 64'(m_done));
        chk("ap_start", 64'(task_ap_start), 64'(m_launching));
        chk("done_valid", 64'(done_valid), 64'(m_dv));
        chk("err", 64'(err), 64'(m_err));
        chk("busy", 64'(busy), 64'(m_launching || (m_infl != 0) || m_dv));
        chk("token_q", 64'(token_q), 64'(m_tok));
        if (!ap_rst_n) begin
            chk("start_read_in_reset", 64'(start_read), 64'd0);
            chk("continue_in_reset", 64'(task_ap_continue), 64'd0);
            m_launching = 0; m_infl = 0; m_launch = '0; m_done = '0;
            m_dv = 0; m_err = 0; m_tok = '0;
        end else begin
            was_launching = m_launching;
            chk("start_read", 64'(start_read),
                64'(!was_launching && start_empty_n && (m_infl < MI)));
            chk("continue", 64'(task_ap_continue), 64'(task_ap_done && !m_dv));
            if (start_read) begin
                if (exp_tok.size() == 0) chk("pop_with_no_token", 64'd1, 64'd0);
                else m_tok = exp_tok.pop_front();
                m_launching = 1;
                pop_evt = 1;
            end
            if (task_ap_continue) begin
                m_done = m_done + 1'b1;
                m_dv = 1;
                cont_evt = 1;
                if (m_infl == 0) m_err = 1;
                else m_infl--;
            end else if (done_ack) begin
                m_dv = 0;
            end
            if (task_ap_ready) begin
                if (was_launching) begin
                    m_launching = 0;
                    m_launch = m_launch + 1'b1;
                    m_infl++;
                    launch_evt = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    task automatic push_tok();
        logic [DW-1:0] t;
        t = DW'($urandom);
        fifo_q.push_back(t);
        exp_tok.push_back(t);
        pushed_since_rst++;
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
        cyc++;
        if (pop_evt) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_evt = 0;
        end
        if (launch_evt) begin
            proc_q.push_back(cyc + longint'($urandom_range(lat_hi, lat_lo)));
            launch_evt = 0;
        end
        if (cont_evt) begin
            if (proc_q.size() != 0) void'(proc_q.pop_front());
            cont_evt = 0;
        end
        if (!ap_rst_n) proc_q.delete();
        if (($urandom % 100) < push_pct) push_tok();
        start_empty_n = (fifo_q.size() != 0);
        start_dout    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        task_ap_ready = force_rdy || (task_ap_start && (($urandom % 100) < rdy_pct));
        task_ap_done  = force_done || (proc_q.size() != 0 && proc_q[0] <= cyc);
        done_ack      = (($urandom % 100) < ack_pct);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input string name);
        int k;
        push_pct = 0; rdy_pct = 100; ack_pct = 100; lat_lo = 0; lat_hi = 3;
        k = 0;
        while ((fifo_q.size() != 0 || busy) && k < 600) begin
            step();
            k++;
        end
        chk({name, "_drain_timeout"}, 64'(k < 600), 64'd1);
        run(2);
        chk({name, "_launches"}, 64'(launch_cnt), 64'(pushed_since_rst));
        chk({name, "_retires"}, 64'(done_cnt), 64'(pushed_since_rst));
    endtask

    initial begin
        int k;
        // Reset held with tokens available: nothing may be popped.
        ap_rst_n = 1'b0;
        push_tok(); push_tok();
        pushed_since_rst = 0;
        run(4);
        pushed_since_rst = 2;
        ap_rst_n = 1'b1;

        // Single tasks, prompt process, moderate latency.
        rdy_pct = 100; lat_lo = 10; lat_hi = 10; ack_pct = 100;
        run(40);

        // General random traffic.
        push_pct = 30; rdy_pct = 60; lat_lo = 0; lat_hi = 15; ack_pct = 70;
        run(250);
        drain("random");

        // Inflight cap: five tokens, long completion latency.
        for (int i = 0; i < 5; i++) push_tok();
        rdy_pct = 100; lat_lo = 40; lat_hi = 40; ack_pct = 100;
        run(30);
        chk("cap_launches", 64'(launch_cnt), 64'(pushed_since_rst - 3));
        drain("cap");

        // Completion backpressure: controller stalls.
        push_tok(); push_tok();
        rdy_pct = 100; lat_lo = 2; lat_hi = 4; ack_pct = 0;
        run(25);
        chk("bp_done_valid", 64'(done_valid), 64'd1);
        chk("bp_one_retired", 64'(done_cnt), 64'(pushed_since_rst - 1));
        drain("bp");

        // High throughput to provoke ready and continue on the same edge.
        push_pct = 70; rdy_pct = 100; lat_lo = 0; lat_hi = 2; ack_pct = 100;
        run(300);
        drain("fast");

        // Reset while a launch is pending.
        push_tok();
        rdy_pct = 0;
        k = 0;
        while (!task_ap_start && k < 20) begin step(); k++; end
        chk("t6_start_seen", 64'(task_ap_start), 64'd1);
        ap_rst_n = 1'b0;
        run(1);
        chk("t6_start_dropped", 64'(task_ap_start), 64'd0);
        ap_rst_n = 1'b1;
        pushed_since_rst = 0;
        run(5);
        chk("t6_fifo_untouched", 64'(fifo_q.size()), 64'd0);

        // Spurious ready while idle.
        force_rdy = 1; run(1); force_rdy = 0;
        run(3);
        chk("spurious_ready_err", 64'(err), 64'd1);

        // Reset clears error; then a done with nothing in flight.
        ap_rst_n = 1'b0; run(2); ap_rst_n = 1'b1;
        run(2);
        force_done = 1; run(1); force_done = 0;
        run(10);
        chk("spurious_done_err", 64'(err), 64'd1);
        chk("spurious_done_cnt", 64'(done_cnt), 64'd1);
        chk("spurious_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
